// File: rtl/ram_pkg.sv
// Shared types and defaults for the 16x8 RAM BIST engine.
package ram_pkg;

  localparam int unsigned RamAddrW   = 4;
  localparam int unsigned RamDataW   = 8;
  localparam int unsigned RamDepth   = 2 ** RamAddrW;
  localparam logic [7:0]  RamPattern = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StRd0,
    StWr1,
    StRd1,
    StDone
  } bist_state_e;

  typedef struct packed {
    logic                valid;
    logic [RamAddrW-1:0] addr;
    logic                phase;
  } cmp_tag_t;

endpackage

// File: rtl/ram_bist_cmp.sv
// Registered read-data compare stage: error counter and first-failure latch.
module ram_bist_cmp
  import ram_pkg::*;
#(
  parameter int unsigned       ADDR_W  = RamAddrW,
  parameter int unsigned       DATA_W  = RamDataW,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(RamPattern)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  cmp_tag_t          i_tag,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W+1:0] o_err_cnt,
  output logic              o_err_zero_d,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic              o_fail_phase
);

  logic [ADDR_W+1:0] r_err_cnt, w_err_cnt_d;
  logic [ADDR_W-1:0] r_fail_addr;
  logic              r_fail_phase;
  logic [DATA_W-1:0] w_exp;
  logic              w_miscmp;

  always_comb begin
    w_exp = PATTERN ^ DATA_W'(i_tag.addr);
    if (i_tag.phase) begin
      w_exp = ~w_exp;
    end
    w_miscmp = i_tag.valid && (i_rdata != w_exp);
    w_err_cnt_d = r_err_cnt;
    if (i_clear) begin
      w_err_cnt_d = '0;
    end else if (w_miscmp && !(&r_err_cnt)) begin
      w_err_cnt_d = r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_fail_addr  <= '0;
      r_fail_phase <= 1'b0;
    end else begin
      r_err_cnt <= w_err_cnt_d;
      if (i_clear) begin
        r_fail_addr  <= '0;
        r_fail_phase <= 1'b0;
      end else if (w_miscmp && (r_err_cnt == '0)) begin
        r_fail_addr  <= i_tag.addr;
        r_fail_phase <= i_tag.phase;
      end
    end
  end

  assign o_err_cnt    = r_err_cnt;
  assign o_err_zero_d = (w_err_cnt_d == '0);
  assign o_fail_addr  = r_fail_addr;
  assign o_fail_phase = r_fail_phase;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Two-pass write/read-compare march BIST for a single-port synchronous RAM
// with one cycle of read latency. All RAM-side and status outputs are registered.
module ram_bist_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned       ADDR_W  = RamAddrW,
  parameter int unsigned       DATA_W  = RamDataW,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(RamPattern)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam int unsigned     CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] DrainIdx = CntW'(DEPTH);

  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a, input logic p);
    logic [DATA_W-1:0] w;
    w = PATTERN ^ DATA_W'(a);
    return p ? ~w : w;
  endfunction

  bist_state_e       r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  cmp_tag_t          r_tag, w_tag_d;
  logic              w_clear, w_err_zero_d;
  logic              r_mem_wr_en, w_mem_wr_en_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_pass;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_clear   = 1'b0;
    w_tag_d   = '0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StWr0;
          w_cnt_d   = '0;
          w_clear   = 1'b1;
        end
      end
      StWr0, StWr1: begin
        if (r_cnt == LastIdx) begin
          w_cnt_d   = '0;
          w_state_d = (r_state == StWr0) ? StRd0 : StRd1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StRd0, StRd1: begin
        // Tag travels alongside the RAM's one-cycle read latency.
        w_tag_d.valid = (r_cnt != DrainIdx);
        w_tag_d.addr  = r_cnt[ADDR_W-1:0];
        w_tag_d.phase = (r_state == StRd1);
        if (r_cnt == DrainIdx) begin
          w_cnt_d   = '0;
          w_state_d = (r_state == StRd0) ? StWr1 : StDone;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they line up with it once registered.
  always_comb begin
    w_mem_wr_en_d = 1'b0;
    w_mem_addr_d  = '0;
    w_mem_wdata_d = '0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    unique case (w_state_d)
      StWr0, StWr1: begin
        w_mem_wr_en_d = 1'b1;
        w_mem_addr_d  = w_cnt_d[ADDR_W-1:0];
        w_mem_wdata_d = exp_word(w_cnt_d[ADDR_W-1:0], w_state_d == StWr1);
        w_busy_d      = 1'b1;
      end
      StRd0, StRd1: begin
        w_mem_addr_d = (w_cnt_d == DrainIdx) ? ADDR_W'(DEPTH - 1) : w_cnt_d[ADDR_W-1:0];
        w_busy_d     = 1'b1;
      end
      StDone:  w_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_tag       <= w_tag_d;
      r_mem_wr_en <= w_mem_wr_en_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      if (w_clear) begin
        r_pass <= 1'b0;
      end else if (w_state_d == StDone) begin
        r_pass <= w_err_zero_d;
      end
    end
  end

  ram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PATTERN(PATTERN)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_tag       (r_tag),
    .i_rdata     (mem_rdata),
    .o_err_cnt   (err_cnt),
    .o_err_zero_d(w_err_zero_d),
    .o_fail_addr (fail_addr),
    .o_fail_phase(fail_phase)
  );

  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: behavioural 16x8 RAM with injectable faults,
// write and result scoreboards, cycle-exact timing checks.
module tb_ram_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mem_wr_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [3:0] fail_addr;
  logic       fail_phase;

  int checks = 0;
  int errors = 0;
  int fault  = 0;  // 0 none, 1 addr 3 bit0 stuck-at-0 on read, 2 addr[3] ignored

  typedef struct {
    logic [5:0] ec;
    logic [3:0] fa;
    logic       fp;
    logic       ps;
  } res_t;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  res_t rq[$];
  wr_t  wq[$];
  logic [7:0] ram[16];

  ram_bist_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_phase(fail_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [3:0] ea;
    logic [7:0] rd;
    ea = (fault == 2) ? {1'b0, mem_addr[2:0]} : mem_addr;
    rd = ram[ea];
    if (fault == 1 && mem_addr == 4'd3) rd[0] = 1'b0;
    if (mem_wr_en) ram[ea] <= mem_wdata;
    mem_rdata <= rd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, mem_wr_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_phase"}, fail_phase, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run(input int fmode, input logic [5:0] ec, input logic [3:0] fa,
                     input logic fp, input logic ps, input bit extra, input int abort_c);
    res_t r;
    wr_t  w;
    int   ndone;
    bit   exp_wr;
    logic [3:0] exp_addr;
    fault = fmode;
    start = 1'b1;
    r.ec = ec; r.fa = fa; r.fp = fp; r.ps = ps;
    rq.push_back(r);
    for (int i = 0; i < 32; i++) begin
      w.a = 4'(i % 16);
      w.d = 8'hA5 ^ {4'b0, w.a};
      if (i >= 16) w.d = ~w.d;
      wq.push_back(w);
    end
    ndone = 0;
    @(negedge clk);
    for (int c = 1; c <= 70; c++) begin
      start = (extra && (c == 10 || c == 67)) ? 1'b1 : 1'b0;
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        rq.delete();
        wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (c == 1) begin
        check("clr_err_cnt", err_cnt, 0);
        check("clr_fail_addr", fail_addr, 0);
        check("clr_fail_phase", fail_phase, 0);
        check("clr_pass", pass, 0);
      end
      exp_wr = (c >= 1 && c <= 16) || (c >= 34 && c <= 49);
      check("wr_en", mem_wr_en, exp_wr);
      if (mem_wr_en && wq.size() > 0) begin
        w = wq.pop_front();
        check("wr_addr", mem_addr, w.a);
        check("wr_data", mem_wdata, w.d);
      end else if (!exp_wr) begin
        if (c >= 17 && c <= 33) exp_addr = (c == 33) ? 4'd15 : 4'(c - 17);
        else if (c >= 50 && c <= 66) exp_addr = (c == 66) ? 4'd15 : 4'(c - 50);
        else exp_addr = 4'd0;
        check("rd_addr", mem_addr, exp_addr);
        check("rd_wdata", mem_wdata, 0);
      end
      check("busy", busy, (c <= 66));
      check("done", done, (c == 67));
      if (done) begin
        ndone++;
        if (rq.size() > 0) begin
          r = rq.pop_front();
          check("res_err_cnt", err_cnt, r.ec);
          check("res_fail_addr", fail_addr, r.fa);
          check("res_fail_phase", fail_phase, r.fp);
          check("res_pass", pass, r.ps);
        end
      end
      if (c > 67) begin
        check("hold_err_cnt", err_cnt, r.ec);
        check("hold_pass", pass, r.ps);
      end
      @(negedge clk);
    end
    check("done_pulses", ndone, 1);
    check("res_left", rq.size(), 0);
    check("wr_left", wq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 6'd0,  4'd0, 1'b0, 1'b1, 1'b0, 0);   // fault-free
    run(1, 6'd1,  4'd3, 1'b1, 1'b0, 1'b0, 0);   // stuck bit0 at addr 3
    run(2, 6'd16, 4'd0, 1'b0, 1'b0, 1'b0, 0);   // addr[3] aliasing
    run(0, 6'd0,  4'd0, 1'b0, 1'b1, 1'b1, 0);   // stray starts ignored
    run(0, 6'd0,  4'd0, 1'b0, 1'b0, 1'b0, 22);  // reset in RD0 cycle 5
    run(0, 6'd0,  4'd0, 1'b0, 1'b1, 1'b0, 0);   // full rerun after abort
    run(1, 6'd1,  4'd3, 1'b1, 1'b0, 1'b0, 0);   // faulty then ...
    run(0, 6'd0,  4'd0, 1'b0, 1'b1, 1'b0, 0);   // ... fault-free back-to-back

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
